// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame width and counter sizing helper.
// Used by both the master receiver and the slave transmitter.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 16;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE  = 3'd0;
    localparam spi_state_t ST_SETUP = 3'd1;
    localparam spi_state_t ST_LOW   = 3'd2;
    localparam spi_state_t ST_HIGH  = 3'd3;
    localparam spi_state_t ST_DONE  = 3'd4;

    // Bits needed to hold values 0..max_val without wrapping.
    function automatic int cnt_w(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider: one-cycle tick every CLK_DIV cycles while run is high.
// Counter is held at zero when idle so each phase starts a full half-period.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = cnt_w(CLK_DIV - 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    assign tick = run && (div_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (!run || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_rx.sv
// SPI master receiver: runs one DATA_WIDTH frame per accepted start_rx, MSB first.
// Latency start_rx -> rx_valid is 1 + CLK_DIV + 2*(DATA_WIDTH+1)*CLK_DIV cycles.
module spi_master_rx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_rx,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_received,
    output logic                  rx_valid
);

    localparam int FW = cnt_w(DATA_WIDTH + 1);
    localparam logic [FW-1:0] LAST_FALL = FW'(DATA_WIDTH + 1);
    localparam logic [FW-1:0] FIRST_BIT = FW'(1);
    localparam logic [FW-1:0] LAST_BIT  = FW'(DATA_WIDTH);

    spi_state_t            state;
    logic [FW-1:0]         fall_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [1:0]            miso_sync;
    logic                  tick;
    logic                  run;

    assign run = (state == ST_SETUP) || (state == ST_LOW) || (state == ST_HIGH);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miso_sync <= '0;
        end else begin
            miso_sync <= {miso_sync[0], miso};
        end
    end

    // The first falling edge only lets the slave drive its MSB, so sampling
    // happens on rising edges 1..DATA_WIDTH; the extra final rising edge is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            sclk          <= 1'b1;
            cs_n          <= 1'b1;
            busy          <= 1'b0;
            rx_valid      <= 1'b0;
            data_received <= '0;
            fall_cnt      <= '0;
            shift_reg     <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_rx) begin
                        state     <= ST_SETUP;
                        cs_n      <= 1'b0;
                        busy      <= 1'b1;
                        fall_cnt  <= '0;
                        shift_reg <= '0;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state    <= ST_LOW;
                        sclk     <= 1'b0;
                        fall_cnt <= fall_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (tick) begin
                        state <= ST_HIGH;
                        sclk  <= 1'b1;
                        if (fall_cnt >= FIRST_BIT && fall_cnt <= LAST_BIT) begin
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], miso_sync[1]};
                        end
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        if (fall_cnt < LAST_FALL) begin
                            state    <= ST_LOW;
                            sclk     <= 1'b0;
                            fall_cnt <= fall_cnt + 1'b1;
                        end else begin
                            state         <= ST_DONE;
                            cs_n          <= 1'b1;
                            data_received <= shift_reg;
                            rx_valid      <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    sclk  <= 1'b1;
                    cs_n  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
